// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI word width, counter sizing and the transmit-queue FSM
// state encoding used by spi_tx_queue and the neighbouring SPI benches.
package spi_pkg;

  // Width of one SPI word as seen by the downstream master.
  localparam int unsigned SPI_DW = 12;

  // Timeout and gap counters both cover 0..255.
  localparam int unsigned CNT_W = 8;

  typedef logic [SPI_DW-1:0] spi_word_t;
  typedef logic [CNT_W-1:0]  spi_cnt_t;

  // Launch/handshake FSM states of the transmit queue.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,  // waiting for a queued word
    ST_WAIT_START = 2'd1,  // word launched, waiting for cs to fall
    ST_WAIT_END   = 2'd2,  // transfer running, waiting for cs to rise
    ST_GAP        = 2'd3   // enforced idle time between transfers
  } spi_state_e;

  // Terminal count for a counter that must span 'cycles' clock cycles,
  // counting 0 .. cycles-1. A zero-length span maps to 0 and the caller
  // is expected to bypass the counter in that case.
  function automatic spi_cnt_t cnt_last(input int unsigned cycles);
    if (cycles == 0) begin
      return '0;
    end
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: synchronous word FIFO for the SPI transmit queue.
// Holds storage, wrapping read/write pointers and the occupancy count.
// A push is refused while full even if a pop happens on the same edge, and
// there is no bypass: a word written on edge N is readable from edge N on,
// so the consumer can pop it at edge N+1 at the earliest.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  spi_word_t                wr_data_i,
  input  logic                     pop_i,
  output spi_word_t                rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  spi_word_t        mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come straight from the registered level, so the ready seen
  // by the producer never depends on what the consumer does this cycle.
  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Next-state for pointers and level; pointers wrap naturally at DEPTH.
  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves it unassigned,
    // which keeps this block free of inferred latches.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Word storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; only locations between the
    // pointers are ever read, and those were written after reset.
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/spi_tx_queue.sv
// spi_tx_queue: buffers 12-bit words from a valid/ready producer and hands
// them one at a time to a downstream SPI master. Each word is launched with a
// one-cycle newd strobe and held on din until the master has finished
// (cs low then high again) and an idle gap has elapsed. If the master never
// drops cs, the launch is abandoned after TIMEOUT cycles and err_timeout
// pulses once.
module spi_tx_queue
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [SPI_DW-1:0]        s_data,
  output logic                     s_ready,
  input  logic                     cs,
  output logic                     newd,
  output logic [SPI_DW-1:0]        din,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     err_timeout
);

  // Terminal counts for the WAIT_START timeout and the inter-transfer gap.
  localparam spi_cnt_t TMO_LAST = cnt_last(TIMEOUT);
  localparam spi_cnt_t GAP_LAST = cnt_last(GAP_CYCLES);

  spi_state_e  state_q;
  spi_word_t   din_q;
  logic        newd_q;
  logic        err_q;
  spi_cnt_t    tmo_cnt_q;
  spi_cnt_t    gap_cnt_q;

  spi_word_t   head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  // A word is taken from the FIFO only in IDLE, on the same edge that the
  // FSM registers it on din and raises newd.
  assign pop = (state_q == ST_IDLE) && !fifo_empty;

  spi_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (s_valid),
    .wr_data_i (s_data),
    .pop_i     (pop),
    .rd_data_o (head),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign s_ready     = !fifo_full;
  assign newd        = newd_q;
  assign din         = din_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != ST_IDLE);

  // Launch/handshake FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      din_q     <= '0;
      newd_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      newd_q <= 1'b0;
      err_q  <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            din_q     <= head;
            newd_q    <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= ST_WAIT_START;
          end
        end

        ST_WAIT_START: begin
          if (!cs) begin
            tmo_cnt_q <= '0;
            state_q   <= ST_WAIT_END;
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Master never started: drop the word and report it once.
            err_q     <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        ST_WAIT_END: begin
          if (cs) begin
            gap_cnt_q <= '0;
            state_q   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_queue.sv
// tb_spi_tx_queue: scoreboard bench for spi_tx_queue. Accepted words are
// queued when the producer handshake completes; each newd pops the oldest
// expected word and compares it with din. A small cs model plays the SPI
// master. Directed sequences cover latency, hold, gap, full/blocked push,
// timeout and mid-transfer reset.
`timescale 1ns/1ps
module tb_spi_tx_queue;
  import spi_pkg::*;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int unsigned TIMEOUT    = 15;
  localparam int unsigned LW         = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [SPI_DW-1:0] s_data;
  logic              s_ready;
  logic              cs;
  logic              newd;
  logic [SPI_DW-1:0] din;
  logic [LW-1:0]     level;
  logic              busy;
  logic              err_timeout;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [SPI_DW-1:0] sb [$];
  int unsigned cyc = 0;
  int          newd_cnt = 0;

  // cs model controls
  bit          cs_auto = 1'b0;
  int          cs_low_cycles = 24;
  bit          rise_valid = 1'b0;
  int unsigned rise_cyc = 0;
  bit          chk_gap = 1'b0;

  spi_tx_queue #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .cs          (cs),
    .newd        (newd),
    .din         (din),
    .level       (level),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: record the handshake the coming edge will complete, then
  // advance to 1ns after the edge where outputs are stable.
  task automatic step(output bit acc);
    acc = s_valid && s_ready && !rst;
    if (acc) sb.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bit a;
    step(a);
  endtask

  // Scoreboard: every launch strobe must carry the oldest accepted word.
  always @(negedge clk) begin
    if (!rst && newd) begin
      newd_cnt++;
      if (sb.size() == 0) check("newd_unexpected", 32'(newd), 32'(0));
      else                check("din_order", 32'(din), 32'(sb.pop_front()));
      if (chk_gap && rise_valid) check("gap_len", cyc - rise_cyc, GAP_CYCLES + 2);
    end
  end

  // SPI master model: drop cs one cycle after newd, hold it low, release.
  initial begin
    cs = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (cs_auto && newd) begin
        @(posedge clk);
        #1;
        cs = 1'b0;
        repeat (cs_low_cycles) @(posedge clk);
        #1;
        cs = 1'b1;
        rise_cyc   = cyc;
        rise_valid = 1'b1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not reach the summary, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int n_acc;
    int cnt;
    int n0;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) tick();

    // Reset state
    check("rst_level",   32'(level), 32'(0));
    check("rst_busy",    32'(busy), 32'(0));
    check("rst_newd",    32'(newd), 32'(0));
    check("rst_din",     32'(din), 32'(0));
    check("rst_err",     32'(err_timeout), 32'(0));
    check("rst_ready",   32'(s_ready), 32'(1));
    rst = 1'b0;
    tick();

    // Single word: latency, din hold, busy duration
    cs_auto       = 1'b1;
    cs_low_cycles = 24;
    s_valid = 1'b1;
    s_data  = 12'hA5C;
    check("t1_ready", 32'(s_ready), 32'(1));
    step(acc);
    s_valid = 1'b0;
    check("t1_no_bypass_newd", 32'(newd), 32'(0));
    check("t1_level_after_push", 32'(level), 32'(1));
    check("t1_idle_after_push", 32'(busy), 32'(0));
    tick();
    check("t1_newd", 32'(newd), 32'(1));
    check("t1_din", 32'(din), 32'h0A5C);
    check("t1_level_after_pop", 32'(level), 32'(0));
    cnt = 0;
    while (busy && cnt < 100) begin
      check("t1_din_stable", 32'(din), 32'h0A5C);
      if (cnt > 0) check("t1_newd_single", 32'(newd), 32'(0));
      cnt++;
      tick();
    end
    check("t1_busy_len", cnt, 2 + 24 + GAP_CYCLES);

    // Three words in order with the enforced gap
    cs_low_cycles = 3;
    rise_valid    = 1'b0;
    chk_gap       = 1'b1;
    n0            = newd_cnt;
    s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = SPI_DW'(i);
      step(acc);
    end
    s_valid = 1'b0;
    cnt = 0;
    while ((busy || level != 0) && cnt < 200) begin
      tick();
      cnt++;
    end
    check("t2_drain_in_time", 32'(cnt < 200), 32'(1));
    check("t2_launch_count", newd_cnt - n0, 3);
    chk_gap = 1'b0;

    // cs stuck high: fill, blocked push on pop cycle, timeout
    cs_auto = 1'b0;
    cs      = 1'b1;
    n_acc   = 0;
    s_valid = 1'b1;
    s_data  = 12'h100;
    for (int i = 0; i < 12; i++) begin
      step(acc);
      if (acc) begin
        n_acc++;
        s_data = s_data + 1'b1;
      end
      check("t3_level_bound", 32'(level <= DEPTH), 32'(1));
    end
    check("t3_accepted", n_acc, 9);
    check("t3_ready_full", 32'(s_ready), 32'(0));
    check("t3_level_full", 32'(level), 32'(DEPTH));
    cnt = 0;
    while (!err_timeout && cnt < 40) begin
      step(acc);
      if (acc) s_data = s_data + 1'b1;
      cnt++;
    end
    check("t3_err_seen", 32'(err_timeout), 32'(1));
    check("t3_ready_at_pop", 32'(s_ready), 32'(0));
    step(acc);
    check("t3_err_one_cycle", 32'(err_timeout), 32'(0));
    check("t3_relaunch", 32'(newd), 32'(1));
    check("t3_level_after_pop", 32'(level), 32'(DEPTH - 1));
    check("t3_ready_after_pop", 32'(s_ready), 32'(1));
    step(acc);
    if (acc) s_data = s_data + 1'b1;
    s_valid = 1'b0;
    check("t3_level_refill", 32'(level), 32'(DEPTH));
    cnt = 1;
    while (!err_timeout && cnt < 40) begin
      tick();
      cnt++;
    end
    check("t3_timeout_cycles", cnt, TIMEOUT);
    cs_auto       = 1'b1;
    cs_low_cycles = 2;
    tick();
    check("t3_err_pulse_end", 32'(err_timeout), 32'(0));
    check("t3_next_launch", 32'(newd), 32'(1));
    cnt = 0;
    while ((busy || level != 0) && cnt < 2000) begin
      tick();
      cnt++;
    end
    check("t3_drain_in_time", 32'(cnt < 2000), 32'(1));
    check("t3_sb_empty", sb.size(), 0);

    // Reset while in WAIT_END with three words queued
    cs_low_cycles = 24;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = SPI_DW'(12'h200 + i);
      step(acc);
    end
    s_valid = 1'b0;
    tick();
    tick();
    check("t4_pre_level", 32'(level), 32'(3));
    check("t4_pre_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    tick();
    sb.delete();
    check("t4_rst_level", 32'(level), 32'(0));
    check("t4_rst_busy", 32'(busy), 32'(0));
    check("t4_rst_newd", 32'(newd), 32'(0));
    check("t4_rst_din", 32'(din), 32'(0));
    check("t4_rst_ready", 32'(s_ready), 32'(1));
    rst = 1'b0;
    n0  = newd_cnt;
    repeat (40) tick();
    check("t4_no_newd_after_rst", newd_cnt - n0, 0);
    check("t4_level_stays_0", 32'(level), 32'(0));

    // A fresh push after reset launches normally
    cs_low_cycles = 2;
    s_valid = 1'b1;
    s_data  = 12'h3C3;
    step(acc);
    s_valid = 1'b0;
    tick();
    check("t5_newd", 32'(newd), 32'(1));
    check("t5_din", 32'(din), 32'h03C3);
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
    check("t5_idle_in_time", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
